// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipelined control unit: opcodes, control-bundle
// layout and the halt sequencer state encoding.
package pipe_ctrl_pkg;

   localparam logic [3:0] OP_SHIFT_LO = 4'b0100;
   localparam logic [3:0] OP_SHIFT_HI = 4'b0110;
   localparam logic [3:0] OP_LW       = 4'b1000;
   localparam logic [3:0] OP_SW       = 4'b1001;
   localparam logic [3:0] OP_LLB      = 4'b1010;
   localparam logic [3:0] OP_LHB      = 4'b1011;
   localparam logic [3:0] OP_B        = 4'b1100;
   localparam logic [3:0] OP_BR       = 4'b1101;
   localparam logic [3:0] OP_PCS      = 4'b1110;
   localparam logic [3:0] OP_HLT      = 4'b1111;

   // Control bundle bit positions, LSB first; an all-zero bundle is a bubble.
   localparam int CTRLW         = 10;
   localparam int B_VALID       = 0;
   localparam int B_REG_WRITE   = 1;
   localparam int B_REG_DST     = 2;
   localparam int B_ALU_SRC_IMM = 3;
   localparam int B_MEM_READ    = 4;
   localparam int B_MEM_WRITE   = 5;
   localparam int B_MEM_TO_REG  = 6;
   localparam int B_MEM_HALF    = 7;
   localparam int B_PCS         = 8;
   localparam int B_HALT        = 9;

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_DRAIN  = 2'd1,
      ST_HALTED = 2'd2
   } halt_state_e;

endpackage

// File: rtl/pipe_ctrl_decode.sv
// Combinational ID-stage decoder: opcode to control bundle, plus flags telling
// the hazard logic which register fields the instruction actually reads.
module ctrl_decode
   import pipe_ctrl_pkg::*;
#(
   parameter int OPW = 4
) (
   input  logic [OPW-1:0]   opcode,
   output logic [CTRLW-1:0] ctrl,
   output logic             use_rs,
   output logic             use_rt,
   output logic             use_rd
);

   always_comb begin
      ctrl   = '0;
      use_rs = 1'b0;
      use_rt = 1'b0;
      use_rd = 1'b0;
      ctrl[B_VALID] = 1'b1;
      // PCS writes its result through reg_write alone; the pcs bit stays low.
      ctrl[B_PCS]   = 1'b0;
      if (!opcode[OPW-1]) begin
         ctrl[B_REG_WRITE] = 1'b1;
         ctrl[B_REG_DST]   = 1'b1;
         use_rs            = 1'b1;
         // Shift/rotate carry an immediate in the rt field, so rt is not read.
         if (opcode >= OPW'(OP_SHIFT_LO) && opcode <= OPW'(OP_SHIFT_HI)) begin
            ctrl[B_ALU_SRC_IMM] = 1'b1;
         end else begin
            use_rt = 1'b1;
         end
      end else begin
         case (opcode)
            OPW'(OP_LW): begin
               ctrl[B_REG_WRITE]   = 1'b1;
               ctrl[B_MEM_READ]    = 1'b1;
               ctrl[B_MEM_TO_REG]  = 1'b1;
               ctrl[B_ALU_SRC_IMM] = 1'b1;
               use_rs              = 1'b1;
            end
            OPW'(OP_SW): begin
               ctrl[B_MEM_WRITE]   = 1'b1;
               ctrl[B_ALU_SRC_IMM] = 1'b1;
               use_rs              = 1'b1;
               use_rt              = 1'b1;
            end
            OPW'(OP_LLB): begin
               ctrl[B_REG_WRITE] = 1'b1;
               use_rd            = 1'b1;
            end
            OPW'(OP_LHB): begin
               ctrl[B_REG_WRITE] = 1'b1;
               ctrl[B_MEM_HALF]  = 1'b1;
               use_rd            = 1'b1;
            end
            OPW'(OP_B): begin
               ctrl[B_VALID] = 1'b1;
            end
            OPW'(OP_BR): begin
               use_rs = 1'b1;
            end
            OPW'(OP_PCS): begin
               ctrl[B_REG_WRITE] = 1'b1;
            end
            OPW'(OP_HLT): begin
               ctrl[B_HALT] = 1'b1;
            end
            default: begin
               ctrl = '0;
            end
         endcase
      end
   end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipelined control unit: decodes ID, carries bundles through EX/MEM/WB,
// inserts load-use bubbles, flushes IF/ID on taken branches and sequences HLT.
module pipe_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int OPW   = 4,
   parameter int RAW   = 4,
   parameter int CNTW  = 16,
   parameter int DRAIN = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             id_valid,
   input  logic [OPW-1:0]   opcode,
   input  logic [RAW-1:0]   rs,
   input  logic [RAW-1:0]   rt,
   input  logic [RAW-1:0]   rd,
   input  logic             branch_taken,
   output logic             stall,
   output logic             flush_ifid,
   output logic [CTRLW-1:0] ex_ctrl,
   output logic [CTRLW-1:0] mem_ctrl,
   output logic [CTRLW-1:0] wb_ctrl,
   output logic [RAW-1:0]   ex_rd,
   output logic [RAW-1:0]   mem_rd,
   output logic [RAW-1:0]   wb_rd,
   output logic             halted,
   output logic [CNTW-1:0]  stall_cnt
);

   localparam int DCW = (DRAIN > 1) ? $clog2(DRAIN) : 1;

   halt_state_e      state, next_state;
   logic [DCW-1:0]   drain_cnt;
   logic [CTRLW-1:0] id_ctrl;
   logic             use_rs, use_rt, use_rd;
   logic             src_match, load_use, issue, hlt_issue;

   ctrl_decode #(.OPW(OPW)) u_decode (
      .opcode (opcode),
      .ctrl   (id_ctrl),
      .use_rs (use_rs),
      .use_rt (use_rt),
      .use_rd (use_rd)
   );

   // Register 0 is hard-wired zero, so a load targeting it never blocks ID.
   always_comb begin
      src_match = (use_rs && (rs == ex_rd)) ||
                  (use_rt && (rt == ex_rd)) ||
                  (use_rd && (rd == ex_rd));
      load_use  = (state == ST_RUN) && id_valid && ex_ctrl[B_MEM_READ] &&
                  (ex_rd != '0) && src_match;
      issue     = (state == ST_RUN) && id_valid && !load_use;
      hlt_issue = issue && id_ctrl[B_HALT];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_RUN;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         ST_RUN:    if (hlt_issue) next_state = ST_DRAIN;
         ST_DRAIN:  if ((drain_cnt == '0) && wb_ctrl[B_HALT]) next_state = ST_HALTED;
         ST_HALTED: next_state = ST_HALTED;
         default:   next_state = ST_RUN;
      endcase
   end

   // A stall outranks a flush: the branch is re-evaluated once ID is free.
   always_comb begin
      stall      = rst_n && (load_use || (state != ST_RUN));
      flush_ifid = rst_n && (state == ST_RUN) && id_valid && !load_use && branch_taken &&
                   ((opcode == OPW'(OP_B)) || (opcode == OPW'(OP_BR)));
      halted     = (state == ST_HALTED);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         drain_cnt <= '0;
      end else if (hlt_issue) begin
         drain_cnt <= DCW'(DRAIN - 1);
      end else if ((state == ST_DRAIN) && (drain_cnt != '0)) begin
         drain_cnt <= drain_cnt - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_ctrl  <= '0;
         mem_ctrl <= '0;
         wb_ctrl  <= '0;
         ex_rd    <= '0;
         mem_rd   <= '0;
         wb_rd    <= '0;
      end else if (state == ST_HALTED) begin
         ex_ctrl  <= '0;
         mem_ctrl <= '0;
         wb_ctrl  <= '0;
         ex_rd    <= '0;
         mem_rd   <= '0;
         wb_rd    <= '0;
      end else begin
         ex_ctrl  <= issue ? id_ctrl : '0;
         ex_rd    <= issue ? rd : '0;
         mem_ctrl <= ex_ctrl;
         mem_rd   <= ex_rd;
         wb_ctrl  <= mem_ctrl;
         wb_rd    <= mem_rd;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt <= '0;
      end else if (load_use && (stall_cnt != '1)) begin
         stall_cnt <= stall_cnt + 1'b1;
      end
   end

endmodule
